fifo_switch_arbiter: RTL and testbench
======================================

Name: fifo_switch_arbiter

Overview:
Control block for the 4-input / 4-output FIFO switch. It runs the system state machine (RESET/INIT/IDLE/ACTIVE/ERROR) and latches the almost-full/almost-empty thresholds during INIT. Each cycle it arbitrates among the four input FIFOs and moves at most one word to the output FIFO selected by the word's destination field. Output FIFOs that are almost full apply backpressure.

Parameters:
DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination output index.
THR_W, 3, threshold width (matches FIFO depth 8).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
init  in  1  request/hold INIT state
alto  in  THR_W  almost-full threshold, sampled in INIT
bajo  in  THR_W  almost-empty threshold, sampled in INIT
in_empty  in  4  empty flags of input FIFOs 0..3
in_data  in  4*DATA_W  head word of each input FIFO (show-ahead); input i in bits [i*DATA_W +: DATA_W]
out_almost_full  in  4  almost-full flags of output FIFOs 4..7
fifo_error  in  1  OR of all FIFO overflow/underflow errors
pop_in  out  4  one-hot pop to input FIFOs
push_out  out  4  one-hot push to output FIFOs
data_out  out  DATA_W  word to output FIFOs
umbral_alto  out  THR_W  latched almost-full threshold
umbral_bajo  out  THR_W  latched almost-empty threshold
state  out  5  one-hot: [0]RESET [1]INIT [2]IDLE [3]ACTIVE [4]ERROR
idle  out  1  high in IDLE state

Behaviour:
- Reset: asynchronous, active-high; while reset=1, state=RESET (5'b00001).
  - All other outputs 0: pop_in, push_out, data_out, umbral_alto, umbral_bajo, idle.
- RESET -> INIT on the first clk edge after reset deasserts.
- INIT: umbral_alto<=alto and umbral_bajo<=bajo on every edge; the last values sampled while init=1 are kept. No transfers. INIT -> IDLE when init=0.
- IDLE: idle=1. IDLE -> ACTIVE when any in_empty bit is 0. IDLE -> INIT if init=1.
- ACTIVE: arbitration runs, one grant per cycle at most.
  - Candidate i: in_empty[i]=0 and out_almost_full[dest(in_data[i])]=0.
  - Fixed priority: input 0 highest, input 3 lowest.
  - On grant to input i at edge N: pop_in[i]=1 in cycle N.
  - Registered push: push_out[dest]=1 and data_out=in_data[i] in cycle N+1. Latency is 1 cycle from pop to push.
  - pop_in is combinational from registered state and the current flags. push_out/data_out are registered.
  - Pending-push hazard: if a push to output k is pending this cycle, a candidate whose destination is k is blocked. This gives one-cycle margin for the almost-full update.
  - ACTIVE -> IDLE when all in_empty=1 and no push is pending. The pending push completes first.
  - init=1 in ACTIVE is ignored until IDLE is reached.
- ERROR: entered from any non-RESET state when fifo_error=1. The pending push is cancelled; pop_in=0 and push_out=0. Exit only via reset.
- Blocked heads: a blocked input does not block lower-priority inputs with different destinations (no head-of-line blocking across inputs).
- Simultaneous events: fifo_error has priority over all other transitions.
- Boundary: all outputs almost full with inputs non-empty -> stay ACTIVE, pop_in=0, no deadlock. Transfers resume the cycle after the flag drops.
- data_out holds its last value when push_out=0.

Optional Feature:
ROUND_ROBIN_EN:
- Defined: a rotating-priority pointer replaces fixed priority. After a grant to input i, priority order restarts at (i+1) mod 4. The pointer resets to 0 and does not move without a grant.
- Undefined: fixed priority 0>1>2>3, and no pointer register is built.

Test Plan:
- Reset mid-ACTIVE with a push pending -> state=5'b00001 immediately; push_out=0, pop_in=0; umbral_alto=0, umbral_bajo=0.
- init=1 with alto/bajo = 2/1 then 5/3 for one cycle each, then init=0 -> umbral_alto=5, umbral_bajo=3; state=IDLE.
- Inputs 0..3 each hold one word for destinations 0..3 (0x001, 0x101, 0x201, 0x301); all outputs free -> pops on inputs 0,1,2,3 in consecutive cycles; push_out 0001,0010,0100,1000 one cycle later with matching data; then idle=1.
- Inputs 0 and 1 both target output 2, out_almost_full[2]=1 for 3 cycles -> pop_in=0 during those cycles. After release: input 0 popped first, input 1 two cycles later (pending-push block).
- Input 0 blocked on output 1 (almost full), input 3 targets output 0 -> input 3 granted at once.
- fifo_error pulse during a transfer -> state=ERROR; pop_in/push_out stay 0 until reset.
- With ROUND_ROBIN_EN, all four inputs continuously non-empty, distinct destinations -> grant order 0,1,2,3,0,...

Source files
------------

// File: rtl/fifo_switch_arbiter.sv
// Control FSM and input->output arbiter for the 4x4 FIFO switch.
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed priority 0>1>2>3.
module fifo_switch_arbiter #(
    parameter int DATA_W = 10,
    parameter int THR_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [THR_W-1:0]      alto,
    input  logic [THR_W-1:0]      bajo,
    input  logic [3:0]            in_empty,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            out_almost_full,
    input  logic                  fifo_error,
    output logic [3:0]            pop_in,
    output logic [3:0]            push_out,
    output logic [DATA_W-1:0]     data_out,
    output logic [THR_W-1:0]      umbral_alto,
    output logic [THR_W-1:0]      umbral_bajo,
    output logic [4:0]            state,
    output logic                  idle
);
    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        push_out_q, push_out_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [THR_W-1:0]  alto_q, alto_d, bajo_q, bajo_d;
    logic [DATA_W-1:0] head [4];
    logic [1:0]        dest [4];
    logic [3:0]        cand;
    logic              gnt_vld;
    logic [1:0]        gnt_idx;
`ifdef ROUND_ROBIN_EN
    logic [1:0]        ptr_q, ptr_d;
`endif

    // A head is eligible unless its output is almost full or is receiving this cycle's push.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head[i] = in_data[i*DATA_W +: DATA_W];
            dest[i] = head[i][DATA_W-1:DATA_W-2];
            cand[i] = !in_empty[i] && !out_almost_full[dest[i]] && !push_out_q[dest[i]];
        end
    end

    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
`ifdef ROUND_ROBIN_EN
            idx = ptr_q + 2'(k);
`else
            idx = 2'(k);
`endif
            if (cand[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (state_q != ST_ACTIVE || fifo_error) begin
            gnt_vld = 1'b0;
        end
    end

    assign pop_in = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;

    always_comb begin
        state_d    = state_q;
        push_out_d = 4'b0000;
        data_out_d = data_out_q;
        alto_d     = alto_q;
        bajo_d     = bajo_q;
`ifdef ROUND_ROBIN_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    alto_d = alto;
                    bajo_d = bajo;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (!(&in_empty)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (gnt_vld) begin
                    push_out_d[dest[gnt_idx]] = 1'b1;
                    data_out_d = head[gnt_idx];
`ifdef ROUND_ROBIN_EN
                    ptr_d = gnt_idx + 2'd1;
`endif
                end else if ((&in_empty) && (push_out_q == 4'b0000)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
        // Errors override every other transition and drop any in-flight push.
        if (fifo_error && state_q != ST_RESET) begin
            state_d    = ST_ERROR;
            push_out_d = 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            push_out_q <= 4'b0000;
            data_out_q <= '0;
            alto_q     <= '0;
            bajo_q     <= '0;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            push_out_q <= push_out_d;
            data_out_q <= data_out_d;
            alto_q     <= alto_d;
            bajo_q     <= bajo_d;
`ifdef ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign push_out    = push_out_q;
    assign data_out    = data_out_q;
    assign umbral_alto = alto_q;
    assign umbral_bajo = bajo_q;
    assign state       = state_q;
    assign idle        = (state_q == ST_IDLE);
endmodule

// File: tb/tb_fifo_switch_arbiter.sv
// Self-checking bench for fifo_switch_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the switch control rules.
module tb_fifo_switch_arbiter;
    localparam int DW = 10;
    localparam int TW = 3;
    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    logic clk = 1'b0;
    logic reset, init, fifo_error;
    logic [TW-1:0] alto, bajo;
    logic [3:0] in_empty, out_almost_full;
    logic [4*DW-1:0] in_data;
    logic [3:0] pop_in, push_out;
    logic [DW-1:0] data_out;
    logic [TW-1:0] umbral_alto, umbral_bajo;
    logic [4:0] state;
    logic idle;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] in_q [4][$];

    // model state: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
    int            m_st;
    bit            m_pend;
    logic [1:0]    m_pdest;
    logic [DW-1:0] m_last;
    logic [TW-1:0] m_alto, m_bajo;
    int            m_ptr;

    fifo_switch_arbiter #(.DATA_W(DW), .THR_W(TW)) dut (
        .clk(clk), .reset(reset), .init(init), .alto(alto), .bajo(bajo),
        .in_empty(in_empty), .in_data(in_data), .out_almost_full(out_almost_full),
        .fifo_error(fifo_error), .pop_in(pop_in), .push_out(push_out),
        .data_out(data_out), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .state(state), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic drive_in();
        for (int i = 0; i < 4; i++) begin
            in_empty[i] = (in_q[i].size() == 0);
            in_data[i*DW +: DW] = (in_q[i].size() != 0) ? in_q[i][0] : '0;
        end
    endtask

    // Input FIFOs behave like show-ahead FIFOs popped by the DUT.
    task automatic tick();
        logic [3:0] pv;
        #1;
        pv = pop_in;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pv[i] && in_q[i].size() != 0) void'(in_q[i].pop_front());
        end
        drive_in();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        init = 1'b0;
        alto = '0;
        bajo = '0;
        out_almost_full = 4'b0000;
        fifo_error = 1'b0;
        for (int i = 0; i < 4; i++) in_q[i].delete();
        drive_in();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic go_idle(input logic [TW-1:0] a, input logic [TW-1:0] b);
        do_reset();
        tick();
        init = 1'b1;
        alto = a;
        bajo = b;
        tick();
        init = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({state, pop_in, push_out, data_out, umbral_alto, umbral_bajo, idle} !==
            {S_RESET, 4'b0, 4'b0, 10'b0, 3'b0, 3'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got st=%b pop=%b push=%b d=%h ua=%0d ub=%0d idle=%b required st=00001 rest 0",
                     state, pop_in, push_out, data_out, umbral_alto, umbral_bajo, idle);
        end
        tick();
        n_vec++;
        if (state !== S_INIT) begin
            n_err++;
            $display("FAIL reset_to_init: got %b required %b", state, S_INIT);
        end
    endtask

    task automatic test_init();
        do_reset();
        tick();
        init = 1'b1; alto = 3'd2; bajo = 3'd1;
        tick();
        n_vec++;
        if ({umbral_alto, umbral_bajo, state} !== {3'd2, 3'd1, S_INIT}) begin
            n_err++;
            $display("FAIL init_first: got ua=%0d ub=%0d st=%b required 2 1 %b", umbral_alto, umbral_bajo, state, S_INIT);
        end
        alto = 3'd5; bajo = 3'd3;
        tick();
        init = 1'b0; alto = 3'd7; bajo = 3'd7;
        tick();
        n_vec++;
        if ({umbral_alto, umbral_bajo, state, idle} !== {3'd5, 3'd3, S_IDLE, 1'b1}) begin
            n_err++;
            $display("FAIL init_latch: got ua=%0d ub=%0d st=%b idle=%b required 5 3 %b 1",
                     umbral_alto, umbral_bajo, state, idle, S_IDLE);
        end
    endtask

    task automatic test_transfers();
        logic [DW-1:0] words [4];
        int cyc;
        words[0] = 10'h001; words[1] = 10'h101; words[2] = 10'h201; words[3] = 10'h301;
        go_idle(3'd6, 3'd2);
        for (int i = 0; i < 4; i++) in_q[i].push_back(words[i]);
        drive_in();
        #1;
        n_vec++;
        if (pop_in !== 4'b0000) begin
            n_err++;
            $display("FAIL xfer_idle_pop: got %b required 0000", pop_in);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (pop_in !== 4'(1 << k)) begin
                n_err++;
                $display("FAIL xfer_pop%0d: got %b required %b", k, pop_in, 4'(1 << k));
            end
            tick();
            n_vec++;
            if ({push_out, data_out} !== {4'(1 << k), words[k]}) begin
                n_err++;
                $display("FAIL xfer_push%0d: got %b/%h required %b/%h", k, push_out, data_out, 4'(1 << k), words[k]);
            end
        end
        cyc = 0;
        while (idle !== 1'b1 && cyc < 6) begin
            tick();
            cyc++;
        end
        n_vec++;
        if ({idle, push_out, data_out} !== {1'b1, 4'b0000, 10'h301}) begin
            n_err++;
            $display("FAIL xfer_idle: got idle=%b push=%b d=%h required 1 0000 301", idle, push_out, data_out);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        go_idle(3'd6, 3'd2);
        in_q[0].push_back(10'h211);
        in_q[1].push_back(10'h222);
        out_almost_full = 4'b0100;
        drive_in();
        tick();
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if ({pop_in, state} !== {4'b0000, S_ACTIVE}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got pop=%b st=%b required 0000 %b", c, pop_in, state, S_ACTIVE);
            end
            tick();
        end
        out_almost_full = 4'b0000;
        #1;
        n_vec++;
        if (pop_in !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_release: got %b required 0001", pop_in);
        end
        tick();
        n_vec++;
        if ({push_out, data_out, pop_in} !== {4'b0100, 10'h211, 4'b0000}) begin
            n_err++;
            $display("FAIL bp_pending_block: got push=%b d=%h pop=%b required 0100 211 0000", push_out, data_out, pop_in);
        end
        tick();
        n_vec++;
        if ({pop_in, push_out} !== {4'b0010, 4'b0000}) begin
            n_err++;
            $display("FAIL bp_second_pop: got pop=%b push=%b required 0010 0000", pop_in, push_out);
        end
        tick();
        n_vec++;
        if ({push_out, data_out} !== {4'b0100, 10'h222}) begin
            n_err++;
            $display("FAIL bp_second_push: got %b/%h required 0100/222", push_out, data_out);
        end
        cyc = 0;
        while (idle !== 1'b1 && cyc < 6) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (idle !== 1'b1) begin
            n_err++;
            $display("FAIL bp_idle_timeout: got idle=%b required 1", idle);
        end
    endtask

    task automatic test_no_hol();
        go_idle(3'd6, 3'd2);
        in_q[0].push_back(10'h155);
        in_q[3].push_back(10'h033);
        out_almost_full = 4'b0010;
        drive_in();
        tick();
        n_vec++;
        if (pop_in !== 4'b1000) begin
            n_err++;
            $display("FAIL hol_grant3: got %b required 1000", pop_in);
        end
        tick();
        n_vec++;
        if ({push_out, data_out, pop_in} !== {4'b0001, 10'h033, 4'b0000}) begin
            n_err++;
            $display("FAIL hol_push3: got push=%b d=%h pop=%b required 0001 033 0000", push_out, data_out, pop_in);
        end
        out_almost_full = 4'b0000;
        #1;
        tick();
        n_vec++;
        if ({push_out, data_out} !== {4'b0010, 10'h155}) begin
            n_err++;
            $display("FAIL hol_push0: got %b/%h required 0010/155", push_out, data_out);
        end
    endtask

    task automatic test_error();
        go_idle(3'd6, 3'd2);
        in_q[0].push_back(10'h3F0);
        in_q[1].push_back(10'h0AA);
        in_q[2].push_back(10'h1BB);
        drive_in();
        tick();
        n_vec++;
        if (pop_in !== 4'b0001) begin
            n_err++;
            $display("FAIL err_first_pop: got %b required 0001", pop_in);
        end
        tick();
        fifo_error = 1'b1;
        tick();
        fifo_error = 1'b0;
        init = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if ({state, pop_in, push_out} !== {S_ERROR, 4'b0000, 4'b0000}) begin
                n_err++;
                $display("FAIL err_hold%0d: got st=%b pop=%b push=%b required %b 0000 0000", c, state, pop_in, push_out, S_ERROR);
            end
            tick();
        end
        init = 1'b0;
    endtask

    task automatic test_reset_active();
        go_idle(3'd4, 3'd2);
        in_q[0].push_back(10'h001);
        in_q[1].push_back(10'h105);
        drive_in();
        tick();
        tick();
        n_vec++;
        if (push_out !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_act_pending: got %b required 0001", push_out);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({state, push_out, pop_in, umbral_alto, umbral_bajo, data_out} !==
            {S_RESET, 4'b0, 4'b0, 3'd0, 3'd0, 10'h0}) begin
            n_err++;
            $display("FAIL rst_act_async: got st=%b push=%b pop=%b ua=%0d ub=%0d d=%h required 00001 0 0 0 0 0",
                     state, push_out, pop_in, umbral_alto, umbral_bajo, data_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

`ifdef ROUND_ROBIN_EN
    task automatic test_round_robin();
        go_idle(3'd6, 3'd2);
        for (int i = 0; i < 4; i++)
            for (int n = 0; n < 6; n++) in_q[i].push_back(10'((i << 8) | (n + 16 * i)));
        drive_in();
        tick();
        for (int n = 0; n < 8; n++) begin
            n_vec++;
            if (pop_in !== 4'(1 << (n % 4))) begin
                n_err++;
                $display("FAIL rr_order%0d: got %b required %b", n, pop_in, 4'(1 << (n % 4)));
            end
            tick();
        end
    endtask
`endif

    function automatic int model_grant();
        int start;
        logic [DW-1:0] w;
        logic [1:0] d;
        if (m_st != 3 || fifo_error) return -1;
`ifdef ROUND_ROBIN_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (start + k) % 4;
            if (in_q[idx].size() != 0) begin
                w = in_q[idx][0];
                d = w[DW-1:DW-2];
                if (!out_almost_full[d] && !(m_pend && m_pdest == d)) return idx;
            end
        end
        return -1;
    endfunction

    task automatic test_random();
        int g;
        bit all_empty;
        logic [DW-1:0] w;
        logic [3:0] exp_pop, exp_push;
        logic [4:0] exp_st;
        do_reset();
        m_st = 0; m_pend = 0; m_pdest = 2'd0; m_last = '0; m_alto = '0; m_bajo = '0; m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int q;
                q = $urandom_range(0, 3);
                if (in_q[q].size() < 5) in_q[q].push_back(DW'($urandom_range(0, 1023)));
            end
            drive_in();
            for (int i = 0; i < 4; i++) out_almost_full[i] = ($urandom_range(0, 3) == 0);
            init = ($urandom_range(0, 39) == 0);
            alto = TW'($urandom);
            bajo = TW'($urandom);
            #1;
            g = model_grant();
            exp_pop  = (g >= 0) ? 4'(1 << g) : 4'b0000;
            exp_push = m_pend ? 4'(1 << m_pdest) : 4'b0000;
            exp_st   = 5'(1 << m_st);
            n_vec++;
            if ({state, pop_in, push_out, data_out, idle, umbral_alto, umbral_bajo} !==
                {exp_st, exp_pop, exp_push, m_last, (m_st == 2), m_alto, m_bajo}) begin
                n_err++;
                $display("FAIL rand_c%0d: got st=%b pop=%b push=%b d=%h idle=%b ua=%0d ub=%0d required st=%b pop=%b push=%b d=%h idle=%b ua=%0d ub=%0d",
                         c, state, pop_in, push_out, data_out, idle, umbral_alto, umbral_bajo,
                         exp_st, exp_pop, exp_push, m_last, (m_st == 2), m_alto, m_bajo);
            end
            all_empty = 1'b1;
            for (int i = 0; i < 4; i++) if (in_q[i].size() != 0) all_empty = 1'b0;
            case (m_st)
                0: m_st = 1;
                1: if (init) begin m_alto = alto; m_bajo = bajo; end else m_st = 2;
                2: if (init) m_st = 1; else if (!all_empty) m_st = 3;
                3: begin
                    if (g >= 0) begin
                        w = in_q[g][0];
                        m_pend = 1'b1;
                        m_pdest = w[DW-1:DW-2];
                        m_last = w;
                        m_ptr = (g + 1) % 4;
                    end else begin
                        if (all_empty && !m_pend) m_st = 2;
                        m_pend = 1'b0;
                    end
                end
                default: ;
            endcase
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_transfers();
        test_backpressure();
        test_no_hol();
        test_error();
        test_reset_active();
`ifdef ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1);
    end
endmodule
